keypad_scanner: RTL and testbench

Scans a 4x4 passive key matrix by driving one row low at a time and reading the four column lines back. It debounces whole-matrix frames and reports a stable 16-bit pressed map plus a one-cycle event for each newly pressed key. It is the input-side counterpart to the multiplexed seven-segment display driver, and the console's hex keypad and controller front end.

---
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 passive key matrix one row at a time, debounces
// whole-matrix frames and reports a stable pressed map plus a one-cycle event
// (with key index) for each newly pressed key.
module keypad_scanner #(
  parameter int SCAN_PERIOD    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] keys_out,
  output logic        key_valid_out,
  output logic [3:0]  key_code_out
);

  // Dwell counter must hold 0..SCAN_PERIOD; stable counter must hold
  // 0..DEBOUNCE_SCANS.
  localparam int CNT_W = (SCAN_PERIOD < 1) ? 1 : $clog2(SCAN_PERIOD + 1);
  localparam int STB_W = (DEBOUNCE_SCANS < 1) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_PERIOD);
  localparam logic [STB_W-1:0] STABLE_MAX = STB_W'(DEBOUNCE_SCANS);

  // Column synchronizer
  logic [3:0]       col_meta_reg;
  logic [3:0]       col_sync_reg;

  // Row scanner state
  logic [1:0]       row_idx_reg;
  logic [1:0]       row_idx_next;
  logic [CNT_W-1:0] dwell_reg;
  logic [CNT_W-1:0] dwell_next;
  logic             sample_now;
  logic             frame_end;

  // Frame capture and debounce
  logic [3:0]       row_hit;
  logic [15:0]      frame_reg;
  logic [15:0]      frame_next;
  logic [15:0]      cand_reg;
  logic [15:0]      cand_next;
  logic [STB_W-1:0] stable_reg;
  logic [STB_W-1:0] stable_next;

  // Reported outputs
  logic [15:0]      keys_reg;
  logic [15:0]      keys_next;
  logic             valid_reg;
  logic             valid_next;
  logic [3:0]       code_reg;
  logic [3:0]       code_next;
  logic [15:0]      new_press;
  logic [3:0]       first_idx;

  // Two-flop synchronizer; idle columns float high, so reset to all ones.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      col_meta_reg <= 4'b1111;
      col_sync_reg <= 4'b1111;
    end else begin
      col_meta_reg <= col_in;
      col_sync_reg <= col_meta_reg;
    end
  end

  // The row sample happens on the last dwell cycle; the row-3 sample closes a frame.
  assign sample_now = (dwell_reg == DWELL_LAST);
  assign frame_end  = sample_now && (row_idx_reg == 2'd3);

  // Row scanner state register: active row index and dwell counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      row_idx_reg <= 2'd0;
      dwell_reg   <= '0;
    end else begin
      row_idx_reg <= row_idx_next;
      dwell_reg   <= dwell_next;
    end
  end

  // Row scanner next state: dwell, then advance to the next row (3 wraps to 0).
  always_comb begin
    row_idx_next = row_idx_reg;
    dwell_next   = dwell_reg + CNT_W'(1);
    if (sample_now) begin
      dwell_next   = '0;
      row_idx_next = row_idx_reg + 2'd1;
    end
  end

  // Row scanner output: exactly one row driven low.
  always_comb begin
    row_out = ~(4'b0001 << row_idx_reg);
  end

  // Each row slice of the frame is replaced by the inverted columns on its own
  // sample edge. On the frame-end edge frame_next is therefore the completed
  // frame: stored rows 0-2 plus the row-3 bits being sampled right now.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_hit[gi] = sample_now && (row_idx_reg == 2'(gi));
      assign frame_next[gi*4 +: 4] = row_hit[gi] ? ~col_sync_reg
                                                 : frame_reg[gi*4 +: 4];
    end
  endgenerate

  // Frame buffer register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_reg <= '0;
    end else begin
      frame_reg <= frame_next;
    end
  end

  // Keys that are in the completed frame but not yet reported as pressed.
  assign new_press = frame_next & ~keys_reg;

  // Lowest set bit of new_press wins when several keys arrive together.
  always_comb begin
    first_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_press[i]) begin
        first_idx = 4'(i);
      end
    end
  end

  // Debounce and event generation, evaluated only at frame end.
  always_comb begin
    cand_next   = cand_reg;
    stable_next = stable_reg;
    keys_next   = keys_reg;
    valid_next  = 1'b0;
    code_next   = code_reg;
    if (frame_end) begin
      if (frame_next != cand_reg) begin
        cand_next   = frame_next;
        stable_next = STB_W'(1);
      end else if (stable_reg != STABLE_MAX) begin
        stable_next = stable_reg + STB_W'(1);
      end
      if (stable_next == STABLE_MAX) begin
        keys_next = frame_next;
        if (new_press != 16'd0) begin
          valid_next = 1'b1;
          code_next  = first_idx;
        end
      end
    end
  end

  // Debounce state and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cand_reg   <= '0;
      stable_reg <= '0;
      keys_reg   <= '0;
      valid_reg  <= 1'b0;
      code_reg   <= 4'd0;
    end else begin
      cand_reg   <= cand_next;
      stable_reg <= stable_next;
      keys_reg   <= keys_next;
      valid_reg  <= valid_next;
      code_reg   <= code_next;
    end
  end

  assign keys_out      = keys_reg;
  assign key_valid_out = valid_reg;
  assign key_code_out  = code_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a key-matrix model feeds the columns, press
// events are checked against a queue of expected key codes.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys;
  logic        valid;
  logic [3:0]  code;
  logic [15:0] held;

  // Second instance for the minimum configuration.
  logic        rst2;
  logic [3:0]  col2;
  logic [3:0]  row2;
  logic [15:0] keys2;
  logic        valid2;
  logic [3:0]  code2;
  logic [15:0] held2;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(.SCAN_PERIOD(3), .DEBOUNCE_SCANS(2)) dut (
    .clk_in(clk), .rst_in(rst), .col_in(col), .row_out(row),
    .keys_out(keys), .key_valid_out(valid), .key_code_out(code)
  );

  keypad_scanner #(.SCAN_PERIOD(2), .DEBOUNCE_SCANS(1)) dut_min (
    .clk_in(clk), .rst_in(rst2), .col_in(col2), .row_out(row2),
    .keys_out(keys2), .key_valid_out(valid2), .key_code_out(code2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a held key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always_comb begin
    col2 = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held2[r*4+c] && !row2[r]) col2[c] = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", row); end
    checks++; if (keys !== 16'h0) begin errors++; $display("FAIL reset_keys: got %h want 0000", keys); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", code); end
    step(4);
    checks++; if (row !== 4'b1101) begin errors++; $display("FAIL rot_4: got %b want 1101", row); end
    step(4);
    checks++; if (row !== 4'b1011) begin errors++; $display("FAIL rot_8: got %b want 1011", row); end
    step(4);
    checks++; if (row !== 4'b0111) begin errors++; $display("FAIL rot_12: got %b want 0111", row); end
    step(4);
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL rot_16: got %b want 1110", row); end
    $display("test_reset done: row=%b keys=%h", row, keys);
  endtask

  task automatic test_single_press();
    do_reset();
    held = 16'h0040;
    exp_q.push_back(4'd6);
    step(31);
    checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL single_early: keys got %h want 0000", keys); end
    step(1);
    checks++; if (keys !== 16'h0040) begin errors++; $display("FAIL single_keys: got %h want 0040", keys); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_pulse: valid got %b want 1", valid); end
    step(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: valid got %b want 0", valid); end
    step(79);
    checks++; if (keys !== 16'h0040) begin errors++; $display("FAIL single_held: keys got %h want 0040", keys); end
    checks++; if (code !== 4'd6) begin errors++; $display("FAIL single_code_hold: got %0d want 6", code); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: pending %0d want 0", exp_q.size()); end
    held = 16'h0;
    $display("test_single_press done: keys=%h code=%0d", keys, code);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int f = 0; f < 8; f++) begin
      held = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      step(16);
      checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL bounce_f%0d: keys got %h want 0000", f, keys); end
    end
    held = 16'h0;
    $display("test_bounce done: keys=%h", keys);
  endtask

  task automatic test_multi_release();
    do_reset();
    held = 16'h1008;
    exp_q.push_back(4'd3);
    step(31);
    checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL multi_early: keys got %h want 0000", keys); end
    step(1);
    checks++; if (keys !== 16'h1008) begin errors++; $display("FAIL multi_keys: got %h want 1008", keys); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL multi_pulse: valid got %b want 1", valid); end
    checks++; if (code !== 4'd3) begin errors++; $display("FAIL multi_code: got %0d want 3", code); end
    step(16);
    held = 16'h1000;
    step(31);
    checks++; if (keys !== 16'h1008) begin errors++; $display("FAIL release_early: keys got %h want 1008", keys); end
    step(1);
    checks++; if (keys !== 16'h1000) begin errors++; $display("FAIL release_keys: got %h want 1000", keys); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL release_pulse: valid got %b want 0", valid); end
    held = 16'h1008;
    exp_q.push_back(4'd3);
    step(32);
    checks++; if (keys !== 16'h1008) begin errors++; $display("FAIL repress_keys: got %h want 1008", keys); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL repress_pulse: valid got %b want 1", valid); end
    step(4);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL multi_missing: pending %0d want 0", exp_q.size()); end
    held = 16'h0;
    $display("test_multi_release done: keys=%h code=%0d", keys, code);
  endtask

  task automatic test_mid_reset();
    do_reset();
    held = 16'h0020;
    exp_q.push_back(4'd5);
    step(40);
    checks++; if (row !== 4'b1011) begin errors++; $display("FAIL midrst_row2: row got %b want 1011", row); end
    checks++; if (keys !== 16'h0020) begin errors++; $display("FAIL midrst_pre_keys: got %h want 0020", keys); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (row !== 4'b1110) begin errors++; $display("FAIL midrst_row: got %b want 1110", row); end
    checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL midrst_keys: got %h want 0000", keys); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid); end
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d want 0", code); end
    exp_q.push_back(4'd5);
    step(31);
    checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL midrst_early: keys got %h want 0000", keys); end
    step(1);
    checks++; if (keys !== 16'h0020) begin errors++; $display("FAIL midrst_accept: keys got %h want 0020", keys); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL midrst_pulse: valid got %b want 1", valid); end
    step(4);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_missing: pending %0d want 0", exp_q.size()); end
    held = 16'h0;
    $display("test_mid_reset done: keys=%h code=%0d", keys, code);
  endtask

  task automatic test_min_config();
    int pulses;
    rst2 = 1'b1;
    step(1);
    rst2 = 1'b0;
    held2 = 16'h8000;
    step(11);
    checks++; if (keys2 !== 16'h0000) begin errors++; $display("FAIL min_early: keys got %h want 0000", keys2); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL min_early_valid: got %b want 0", valid2); end
    step(1);
    checks++; if (keys2 !== 16'h8000) begin errors++; $display("FAIL min_keys: got %h want 8000", keys2); end
    checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL min_pulse: valid got %b want 1", valid2); end
    checks++; if (code2 !== 4'd15) begin errors++; $display("FAIL min_code: got %0d want 15", code2); end
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (valid2 === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL min_repeat: pulses got %0d want 0", pulses); end
    checks++; if (keys2 !== 16'h8000) begin errors++; $display("FAIL min_held: keys got %h want 8000", keys2); end
    held2 = 16'h0;
    $display("test_min_config done: keys=%h code=%0d", keys2, code2);
  endtask

  initial begin
    rst   = 1'b1;
    rst2  = 1'b1;
    held  = 16'h0;
    held2 = 16'h0;
    // Scoreboard monitor: every pulse must match the next expected code.
    fork
      forever begin
        logic [3:0] exp_code;
        @(negedge clk);
        if (valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: code got %0d want no pulse", code);
          end else begin
            exp_code = exp_q.pop_front();
            if (code !== exp_code) begin
              errors++;
              $display("FAIL pulse_code: got %0d want %0d", code, exp_code);
            end else begin
              $display("pulse code=%0d keys=%h", code, keys);
            end
          end
        end
      end
    join_none
    step(2);
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_release();
    test_mid_reset();
    test_min_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
